// File: rtl/limiter_pdseq_pkg.sv
// Shared definitions for the limiter power-down sequencer: CPU register
// addresses and the per-channel state encoding.
package limiter_pdseq_pkg;

  localparam logic [1:0] ADDR_PD     = 2'd0;
  localparam logic [1:0] ADDR_SETTLE = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_IRQ    = 2'd3;

  typedef enum logic [1:0] {
    CH_UP     = 2'd0,
    CH_DOWN   = 2'd1,
    CH_SETTLE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/limiter_pdseq_ch.sv
// One limiter channel: UP / DOWN / SETTLE sequencing with a settle
// down-counter. o_done flags the edge on which a completed settle returns to UP.
module limiter_pdseq_ch
  import limiter_pdseq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pd_wr,
  input  logic             i_pd_bit,
  input  logic [CNT_W-1:0] i_settle,
  output logic             o_pd,
  output logic             o_rdy,
  output logic             o_done
);

  ch_state_e        r_state;
  ch_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_done;
  logic             r_pd;
  logic             r_rdy;
  logic             w_pd_nxt;
  logic             w_rdy_nxt;

  // Next-state logic; a power-down request overrides everything, including a
  // settle finishing on the same edge, so an aborted settle never reports done.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    if (i_pd_wr && i_pd_bit) begin
      w_state_nxt = CH_DOWN;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        CH_UP: begin
          w_state_nxt = CH_UP;
        end
        CH_DOWN: begin
          if (i_pd_wr) begin
            w_state_nxt = CH_SETTLE;
            w_cnt_nxt   = i_settle;
          end else begin
            w_state_nxt = CH_DOWN;
          end
        end
        CH_SETTLE: begin
          if (r_cnt == '0) begin
            w_state_nxt = CH_UP;
            w_done      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1'b1);
          end
        end
        default: begin
          w_state_nxt = CH_UP;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output values decoded from the next state so pd/rdy come straight from flops.
  always_comb begin
    w_pd_nxt  = 1'b0;
    w_rdy_nxt = 1'b1;
    case (w_state_nxt)
      CH_UP:     begin w_pd_nxt = 1'b0; w_rdy_nxt = 1'b1; end
      CH_DOWN:   begin w_pd_nxt = 1'b1; w_rdy_nxt = 1'b0; end
      CH_SETTLE: begin w_pd_nxt = 1'b0; w_rdy_nxt = 1'b0; end
      default:   begin w_pd_nxt = 1'b0; w_rdy_nxt = 1'b1; end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CH_UP;
      r_cnt   <= '0;
      r_pd    <= 1'b0;
      r_rdy   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pd    <= w_pd_nxt;
      r_rdy   <= w_rdy_nxt;
    end
  end

  assign o_pd   = r_pd;
  assign o_rdy  = r_rdy;
  assign o_done = w_done;

endmodule

// File: rtl/limiter_pdseq.sv
// Limiter power-down sequencer: CPU register block, IRQ pending logic and
// N_CH independently sequenced channels.
module limiter_pdseq
  import limiter_pdseq_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int SETTLE_RST = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [1:0]        address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic [N_CH-1:0]   pd,
  output logic [N_CH-1:0]   rdy,
  output logic              irq
);

  logic              w_wr;
  logic              w_rd;
  logic              w_pd_wr;
  logic [N_CH-1:0]   w_pd;
  logic [N_CH-1:0]   w_rdy;
  logic [N_CH-1:0]   w_done;
  logic [N_CH-1:0]   w_irq_clr;
  logic [N_CH-1:0]   w_irq_nxt;
  logic [DATA_W-1:0] w_rd_data;
  logic [CNT_W-1:0]  r_settle;
  logic [N_CH-1:0]   r_irq;
  logic              r_irq_any;
  logic              r_ready;
  logic [DATA_W-1:0] r_rdata;

  assign w_wr    = valid & wstrb;
  assign w_rd    = valid & ~wstrb;
  assign w_pd_wr = w_wr & (address == ADDR_PD);

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      limiter_pdseq_ch #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .i_pd_wr  (w_pd_wr),
        .i_pd_bit (wdata[g]),
        .i_settle (r_settle),
        .o_pd     (w_pd[g]),
        .o_rdy    (w_rdy[g]),
        .o_done   (w_done[g])
      );
    end
  endgenerate

  // Write-1-to-clear mask; a settle-done set on the same edge wins below.
  always_comb begin
    w_irq_clr = '0;
    if (w_wr && (address == ADDR_IRQ)) begin
      w_irq_clr = N_CH'(wdata);
    end else begin
      w_irq_clr = '0;
    end
  end

  assign w_irq_nxt = (r_irq & ~w_irq_clr) | w_done;

  // Read data mux; PD readback is the live channel pd state.
  always_comb begin
    w_rd_data = '0;
    case (address)
      ADDR_PD:     w_rd_data = DATA_W'(w_pd);
      ADDR_SETTLE: w_rd_data = DATA_W'(r_settle);
      ADDR_STATUS: w_rd_data = DATA_W'({w_pd, 16'(w_rdy)});
      ADDR_IRQ:    w_rd_data = DATA_W'(r_irq);
      default:     w_rd_data = '0;
    endcase
  end

  // CPU-side registers: SETTLE, IRQ pending, handshake and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle  <= CNT_W'(SETTLE_RST);
      r_irq     <= '0;
      r_irq_any <= 1'b0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_ready   <= valid;
      r_irq     <= w_irq_nxt;
      r_irq_any <= |w_irq_nxt;
      if (w_wr && (address == ADDR_SETTLE)) begin
        r_settle <= CNT_W'(wdata);
      end
      if (w_rd) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign pd    = w_pd;
  assign rdy   = w_rdy;
  assign irq   = r_irq_any;

endmodule

// File: tb/tb_limiter_pdseq.sv
// Self-checking bench for limiter_pdseq: directed scenarios plus randomized
// traffic checked against a cycle-count based behavioural model.
module tb_limiter_pdseq;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [1:0]  address;
  logic [31:0] wdata;
  logic        wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [N-1:0] pd;
  logic [N-1:0] rdy;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  // Model: a channel is down, settling until absolute edge m_end, or up.
  int          cyc;
  bit          m_down [N];
  bit          m_sett [N];
  int          m_end  [N];
  logic [N-1:0] m_pend;
  logic [15:0] m_settle;
  logic [31:0] m_rdata;
  logic        m_ready;

  limiter_pdseq dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .address (address),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .rdata   (rdata),
    .ready   (ready),
    .pd      (pd),
    .rdy     (rdy),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_pd();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_down[i];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_rdy();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = !m_down[i] && !m_sett[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_down[i] = 1'b0;
      m_sett[i] = 1'b0;
      m_end[i]  = 0;
    end
    m_pend   = '0;
    m_settle = 16'd100;
    m_rdata  = 32'd0;
    m_ready  = 1'b0;
  endtask

  // One clock: drive an access, take the edge, advance the model, settle #1.
  task automatic tick(input logic v, input logic [1:0] a, input logic [31:0] wd, input logic ws);
    logic [N-1:0] pdv, rdv, done, clr;
    bit pdw;
    valid = v; address = a; wdata = wd; wstrb = ws;
    @(posedge clk);
    cyc++;
    pdv = exp_pd();
    rdv = exp_rdy();
    if (v && !ws) begin
      case (a)
        2'd0:    m_rdata = {28'd0, pdv};
        2'd1:    m_rdata = {16'd0, m_settle};
        2'd2:    m_rdata = {12'd0, pdv, 12'd0, rdv};
        default: m_rdata = {28'd0, m_pend};
      endcase
    end
    m_ready = v;
    pdw = v && ws && (a == 2'd0);
    clr = (v && ws && (a == 2'd3)) ? wd[N-1:0] : '0;
    done = '0;
    for (int i = 0; i < N; i++) begin
      if (pdw && wd[i]) begin
        m_down[i] = 1'b1;
        m_sett[i] = 1'b0;
      end else if (m_sett[i] && cyc == m_end[i]) begin
        m_sett[i] = 1'b0;
        done[i] = 1'b1;
      end else if (pdw && m_down[i]) begin
        m_down[i] = 1'b0;
        m_sett[i] = 1'b1;
        m_end[i]  = cyc + int'(m_settle) + 1;
      end
    end
    m_pend = (m_pend & ~clr) | done;
    if (v && ws && a == 2'd1) m_settle = wd[15:0];
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0; wstrb = 1'b0; address = 2'd0; wdata = 32'd0;
    rst = 1'b1;
    model_reset();
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    valid = 1'b0; wstrb = 1'b0; address = 2'd0; wdata = 32'd0;
    #3 rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (pd !== 4'h0) begin n_errors++; $display("FAIL reset_pd got %h want 0", pd); end
    n_checks++; if (rdy !== 4'hF) begin n_errors++; $display("FAIL reset_rdy got %h want f", rdy); end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq got %b want 0", irq); end
    n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready got %b want 0", ready); end
    n_checks++; if (rdata !== 32'd0) begin n_errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 2'd1, 32'd0, 1'b0);
    n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL settle_rd_ready got %b want 1", ready); end
    n_checks++; if (rdata !== 32'd100) begin n_errors++; $display("FAIL settle_rst_read got %0d want 100", rdata); end
    tick(1'b0, 2'd0, 32'd0, 1'b0);
    n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL ready_drop got %b want 0", ready); end
  endtask

  task automatic test_powerdown();
    do_reset();
    tick(1'b1, 2'd0, 32'h5, 1'b1);
    n_checks++; if (pd !== 4'h5) begin n_errors++; $display("FAIL pd_write got %h want 5", pd); end
    n_checks++; if (rdy !== 4'hA) begin n_errors++; $display("FAIL pd_rdy got %h want a", rdy); end
    tick(1'b1, 2'd2, 32'd0, 1'b0);
    n_checks++; if (rdata !== 32'h0005000A) begin n_errors++; $display("FAIL status_read got %h want 0005000a", rdata); end
    tick(1'b1, 2'd2, 32'hFFFFFFFF, 1'b1);
    n_checks++; if (rdata !== 32'h0005000A) begin n_errors++; $display("FAIL rdata_hold_on_write got %h want 0005000a", rdata); end
    tick(1'b1, 2'd0, 32'd0, 1'b0);
    n_checks++; if (rdata !== 32'h5) begin n_errors++; $display("FAIL pd_readback got %h want 5", rdata); end
  endtask

  task automatic test_settle();
    do_reset();
    tick(1'b1, 2'd1, 32'd3, 1'b1);
    tick(1'b1, 2'd0, 32'h1, 1'b1);
    tick(1'b1, 2'd0, 32'h0, 1'b1);
    n_checks++; if (rdy[0] !== 1'b0 || pd[0] !== 1'b0) begin n_errors++; $display("FAIL settle_enter got pd=%b rdy=%b want 0/0", pd[0], rdy[0]); end
    for (int k = 1; k <= 4; k++) begin
      tick(1'b0, 2'd0, 32'd0, 1'b0);
      n_checks++;
      if (rdy[0] !== (k == 4)) begin n_errors++; $display("FAIL settle_rdy_k%0d got %b want %b", k, rdy[0], (k == 4)); end
    end
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL settle_irq got %b want 1", irq); end
    tick(1'b1, 2'd3, 32'd0, 1'b0);
    n_checks++; if (rdata !== 32'h1) begin n_errors++; $display("FAIL irq_read got %h want 1", rdata); end
    tick(1'b1, 2'd3, 32'h1, 1'b1);
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_clear got %b want 0", irq); end
    // Zero settle time: exactly one cycle in SETTLE
    tick(1'b1, 2'd1, 32'd0, 1'b1);
    tick(1'b1, 2'd0, 32'h2, 1'b1);
    tick(1'b1, 2'd0, 32'h0, 1'b1);
    n_checks++; if (rdy[1] !== 1'b0) begin n_errors++; $display("FAIL settle0_enter got %b want 0", rdy[1]); end
    tick(1'b0, 2'd0, 32'd0, 1'b0);
    n_checks++; if (rdy[1] !== 1'b1 || irq !== 1'b1) begin n_errors++; $display("FAIL settle0_done got rdy=%b irq=%b want 1/1", rdy[1], irq); end
  endtask

  task automatic test_abort();
    do_reset();
    tick(1'b1, 2'd1, 32'd10, 1'b1);
    tick(1'b1, 2'd0, 32'h1, 1'b1);
    tick(1'b1, 2'd0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) tick(1'b0, 2'd0, 32'd0, 1'b0);
    tick(1'b1, 2'd0, 32'h1, 1'b1);
    n_checks++; if (pd[0] !== 1'b1) begin n_errors++; $display("FAIL abort_pd got %b want 1", pd[0]); end
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 2'd0, 32'd0, 1'b0);
      n_checks++;
      if (rdy[0] !== 1'b0 || irq !== 1'b0) begin n_errors++; $display("FAIL abort_c%0d got rdy=%b irq=%b want 0/0", k, rdy[0], irq); end
    end
  endtask

  task automatic test_collision();
    do_reset();
    tick(1'b1, 2'd1, 32'd2, 1'b1);
    tick(1'b1, 2'd0, 32'h2, 1'b1);
    tick(1'b1, 2'd0, 32'h0, 1'b1);
    tick(1'b0, 2'd0, 32'd0, 1'b0);
    tick(1'b0, 2'd0, 32'd0, 1'b0);
    tick(1'b1, 2'd3, 32'h2, 1'b1);
    n_checks++; if (rdy[1] !== 1'b1 || irq !== 1'b1) begin n_errors++; $display("FAIL collision got rdy=%b irq=%b want 1/1", rdy[1], irq); end
    tick(1'b1, 2'd3, 32'd0, 1'b0);
    n_checks++; if (rdata !== 32'h2) begin n_errors++; $display("FAIL collision_read got %h want 2", rdata); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b1, 2'd1, 32'd5, 1'b1);
    tick(1'b1, 2'd0, 32'hF, 1'b1);
    tick(1'b1, 2'd0, 32'h0, 1'b1);
    tick(1'b0, 2'd0, 32'd0, 1'b0);
    tick(1'b0, 2'd0, 32'd0, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (pd !== 4'h0 || rdy !== 4'hF || irq !== 1'b0) begin n_errors++; $display("FAIL rst_mid got pd=%h rdy=%h irq=%b want 0/f/0", pd, rdy, irq); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 2'd0, 32'd0, 1'b0);
      n_checks++;
      if (irq !== 1'b0 || rdy !== 4'hF) begin n_errors++; $display("FAIL rst_mid_c%0d got irq=%b rdy=%h want 0/f", k, irq, rdy); end
    end
  endtask

  task automatic test_random();
    logic [1:0] a;
    logic [31:0] wd;
    logic v, ws;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      v  = ($urandom_range(0, 3) != 0);
      a  = 2'($urandom_range(0, 3));
      ws = 1'($urandom_range(0, 1));
      wd = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
      tick(v, a, wd, ws);
      n_checks++; if (pd !== exp_pd()) begin n_errors++; $display("FAIL rnd_pd c%0d got %h want %h", k, pd, exp_pd()); end
      n_checks++; if (rdy !== exp_rdy()) begin n_errors++; $display("FAIL rnd_rdy c%0d got %h want %h", k, rdy, exp_rdy()); end
      n_checks++; if (irq !== (|m_pend)) begin n_errors++; $display("FAIL rnd_irq c%0d got %b want %b", k, irq, |m_pend); end
      n_checks++; if (ready !== m_ready) begin n_errors++; $display("FAIL rnd_ready c%0d got %b want %b", k, ready, m_ready); end
      n_checks++; if (rdata !== m_rdata) begin n_errors++; $display("FAIL rnd_rdata c%0d got %h want %h", k, rdata, m_rdata); end
    end
  endtask

  initial begin
    cyc = 0;
    rst = 1'b0;
    valid = 1'b0; address = 2'd0; wdata = 32'd0; wstrb = 1'b0;
    model_reset();
    test_reset();
    test_powerdown();
    test_settle();
    test_abort();
    test_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
